// File: rtl/udm_bus_arb_pkg.sv
// udm_bus_arb_pkg: shared types for the two-master bus arbiter.
// Contents: master count, master ID type, arbiter FSM state enum.
package udm_bus_arb_pkg;

    localparam int MST_NUM = 2;

    typedef logic mst_id_t;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } arb_state_e;

endpackage

// File: rtl/udm_bus_arb_idfifo.sv
// udm_bus_arb_idfifo: FIFO of master IDs for outstanding reads.
// Ports: clk_i/rst_i, push_i+id_i write, pop_i read, head_o/full_o/empty_o status.
module udm_bus_arb_idfifo
    import udm_bus_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  mst_id_t id_i,
    input  logic    pop_i,
    output mst_id_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer tells full from empty when indices match.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    mst_id_t     mem_q [DEPTH];
    mst_id_t     mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_i) begin
            mem_d[wr_ptr_q[AW-1:0]] = id_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/udm_bus_arb.sv
// udm_bus_arb: two-master round-robin arbiter onto one req/ack/resp slave.
// Ports: m_* per-master command/ack/resp, s_* slave side, err_o sticky orphan-response flag.
module udm_bus_arb
    import udm_bus_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [MST_NUM-1:0]          m_req_i,
    input  logic [MST_NUM-1:0]          m_we_i,
    input  logic [MST_NUM*ADDR_W-1:0]   m_addr_i,
    input  logic [MST_NUM*DATA_W/8-1:0] m_be_i,
    input  logic [MST_NUM*DATA_W-1:0]   m_wdata_i,
    output logic [MST_NUM-1:0]          m_ack_o,
    output logic [MST_NUM-1:0]          m_resp_o,
    output logic [DATA_W-1:0]           m_rdata_o,
    output logic                        s_req_o,
    output logic                        s_we_o,
    output logic [ADDR_W-1:0]           s_addr_o,
    output logic [DATA_W/8-1:0]         s_be_o,
    output logic [DATA_W-1:0]           s_wdata_o,
    input  logic                        s_ack_i,
    input  logic                        s_resp_i,
    input  logic [DATA_W-1:0]           s_rdata_i,
    output logic                        err_o
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e state_q, state_d;
    mst_id_t    owner_q, owner_d;
    mst_id_t    rr_last_q, rr_last_d;
    logic       err_q, err_d;

    mst_id_t grant;
    mst_id_t fifo_head;
    logic    cmd_req, cmd_we, rd_block, xfer;
    logic    fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Grant is frozen to the owner while BUSY; ties in IDLE go round-robin.
    always_comb begin
        grant = owner_q;
        if (state_q == ST_IDLE) begin
            if (&m_req_i) begin
                grant = ~rr_last_q;
            end else if (m_req_i[1]) begin
                grant = 1'b1;
            end else begin
                grant = 1'b0;
            end
        end
    end

    assign cmd_req   = m_req_i[grant];
    assign cmd_we    = m_we_i[grant];
    assign s_we_o    = cmd_we;
    assign s_addr_o  = grant ? m_addr_i[ADDR_W +: ADDR_W]  : m_addr_i[0 +: ADDR_W];
    assign s_be_o    = grant ? m_be_i[BE_W +: BE_W]        : m_be_i[0 +: BE_W];
    assign s_wdata_o = grant ? m_wdata_i[DATA_W +: DATA_W] : m_wdata_i[0 +: DATA_W];

    // A response popping this cycle frees the slot a new read needs.
    assign rd_block  = !cmd_we && fifo_full && !s_resp_i;
    assign s_req_o   = !rst_i && cmd_req && !rd_block;
    assign xfer      = s_req_o && s_ack_i;
    assign fifo_push = xfer && !cmd_we;
    assign fifo_pop  = !rst_i && s_resp_i && !fifo_empty;

    assign m_ack_o   = {2{xfer}} & {grant, ~grant};
    assign m_resp_o  = {2{fifo_pop}} & {fifo_head, ~fifo_head};
    assign m_rdata_o = s_rdata_i;
    assign err_o     = err_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        err_d     = err_q | (s_resp_i && fifo_empty);
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    rr_last_d = grant;
                end else if (cmd_req) begin
                    state_d = ST_BUSY;
                    owner_d = grant;
                end
            end
            ST_BUSY: begin
                if (xfer) begin
                    rr_last_d = owner_q;
                    state_d   = ST_IDLE;
                end else if (!cmd_req) begin
                    // Owner withdrew without an ack; do not lock the bus.
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
        end
    end

    udm_bus_arb_idfifo #(
        .DEPTH (RD_DEPTH)
    ) u_idfifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .id_i    (grant),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: doc/udm_bus_arb.md
# udm_bus_arb

Two-master round-robin arbiter for the on-chip req/ack/resp bus in the NEXYS4_DDR design. It shares the single slave port (CSR block plus test memory at 0x80000000) between the UDM debug master (m0) and a second master (m1, e.g. a traffic generator or CPU). It tracks outstanding reads so each read response returns to the master that issued it.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- RD_DEPTH, 4, max outstanding reads (power of 2, ≥2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- m_req_i  in  2  per-master request (bit n = master n)
- m_we_i  in  2  per-master write enable
- m_addr_i  in  2×ADDR_W  per-master address, master n at [n*ADDR_W +: ADDR_W]
- m_be_i  in  2×DATA_W/8  per-master byte enables
- m_wdata_i  in  2×DATA_W  per-master write data
- m_ack_o  out  2  per-master accept strobe
- m_resp_o  out  2  per-master read-response strobe
- m_rdata_o  out  DATA_W  read data, shared, valid with m_resp_o
- s_req_o, s_we_o  out  1  slave request / write enable
- s_addr_o, s_be_o, s_wdata_o  out  ADDR_W, DATA_W/8, DATA_W  slave command
- s_ack_i  in  1  slave accept
- s_resp_i  in  1  slave read-response strobe
- s_rdata_i  in  DATA_W  slave read data
- err_o  out  1  sticky: response with no outstanding read

## Operation
- A master holds req/we/addr/be/wdata stable from assertion until its m_ack_o. A transfer happens on a cycle with s_req_o && s_ack_i.
- FSM with states IDLE and BUSY, plus an owner register (1 bit) and a last-served register rr_last.
- IDLE: grant = the requesting master. If both masters request, grant goes to !rr_last. The granted command is driven to the slave combinationally in the same cycle.
  - s_ack_i in that cycle: m_ack_o[grant]=1, rr_last←grant, stay IDLE.
  - otherwise: owner←grant, go to BUSY.
- BUSY: the slave command is muxed from owner and the grant is frozen; the other master's request is ignored.
  - On s_ack_i: m_ack_o[owner]=1, rr_last←owner, go to IDLE.
- Read gating: if the granted command is a read and the ID FIFO holds RD_DEPTH entries, s_req_o=0 and no ack is issued. Writes are never gated.
- An accepted read pushes the master ID into the ID FIFO.
- On s_resp_i the arbiter pops the FIFO head and pulses m_resp_o[head]. m_rdata_o = s_rdata_i.
- A push and a pop in the same cycle are both performed; occupancy is unchanged and is legal even when the FIFO is full.
- s_resp_i with an empty FIFO: set err_o, no m_resp_o pulse, occupancy stays 0. Only reset clears err_o.
- Reset mid-operation: FSM→IDLE, rr_last←1 (m0 wins the first tie), FIFO emptied, err_o←0. Outstanding responses are lost.

## Timing
- All outputs are combinational from registered state and current inputs.
- Zero-cycle arbitration: m_ack_o can assert in the same cycle as the first m_req_i.
- Response latency through the arbiter is 0 cycles.
- While rst_i=1: s_req_o=0, m_ack_o=0, m_resp_o=0. err_o reads 0 from the cycle after the reset edge.
- Maximum throughput is one transfer per cycle. Under continuous contention the masters alternate ack-to-ack, so neither waits more than one transfer.

## Structure
- Package udm_bus_arb_pkg holds:
  - the FSM enum (ST_IDLE, ST_BUSY)
  - master ID typedef (1 bit)
  - MST_NUM=2
- Sub-module udm_bus_arb_idfifo: synchronous FIFO of master IDs with parameter DEPTH.
  - Pointers carry an extra wrap bit; full/empty are derived from the pointers.
  - Inputs push/pop; outputs head/full/empty.
  - Simultaneous push and pop is supported.

## Test plan
- m0 alone writes 0x5a5a5a5a to 0x0, slave acks immediately -> m_ack_o=01 in the same cycle, s_addr_o=0x0, FSM stays IDLE.
- Both masters request continuously, slave acks every cycle -> acks alternate 01,10,01,… with m0 first after reset.
- m1 read from 0x80000004 while slave delays ack 3 cycles, m0 requests meanwhile -> command stays m1's for all 3 cycles, then m1 acked, then m0 is served.
- Four m0 reads to 0x80000000..0C with no responses -> a fifth read is held off with s_req_o=0. A response arriving in the same cycle as a new request frees a slot: the new read is accepted and occupancy stays 4.
- Interleave m0 read then m1 read, responses 0x112233cc then 0xdeadbeef -> m_resp_o=01 with 0x112233cc, then 10 with 0xdeadbeef.
- s_resp_i with no outstanding reads -> err_o=1 and held. Reset asserted mid-BUSY -> next cycle FSM is IDLE, err_o=0, FIFO empty.
